// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: MMIO register offsets,
// CTRL bit positions and the scan-out FSM state type.
package dmem_pkg;

  localparam logic [11:0] OFF_CYCLE   = 12'h000;
  localparam logic [11:0] OFF_CTRL    = 12'h004;
  localparam logic [11:0] OFF_FB_BASE = 12'h008;

  // CTRL write uses bit0 as the start strobe; reads return {done, busy}.
  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_BUSY_BIT  = 0;
  localparam int CTRL_DONE_BIT  = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    PRESENT = 2'd2
  } scan_state_t;

endpackage

// File: rtl/dmem_scanout.sv
// Framebuffer scan-out engine: walks FB_ROWS words starting at fb_base and
// presents each one on a valid/ready row interface, one row per frame slot.
module dmem_scanout
  import dmem_pkg::*;
#(
  parameter int AW      = 10,
  parameter int FB_ROWS = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [AW-1:0]              fb_base,
  output logic [AW-1:0]              rd_addr,
  input  logic [31:0]                rd_data,
  input  logic                       row_ready,
  output logic                       row_valid,
  output logic [31:0]                row_data,
  output logic [$clog2(FB_ROWS)-1:0] row_idx,
  output logic                       busy,
  output logic                       frame_done
);

  localparam int RW = $clog2(FB_ROWS);
  localparam logic [RW-1:0] LAST_ROW = RW'(FB_ROWS - 1);

  scan_state_t   state_q;
  logic [RW-1:0] row_q;
  logic [RW-1:0] row_idx_q;
  logic [31:0]   row_data_q;
  logic          row_valid_q;
  logic          busy_q;
  logic          frame_done_q;

  // Address is sampled at the FETCH edge, so a mid-frame FB_BASE change
  // lands on the next fetched row; the sum wraps naturally at DEPTH.
  assign rd_addr = fb_base + AW'(row_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      row_q        <= '0;
      row_idx_q    <= '0;
      row_data_q   <= '0;
      row_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q      <= FETCH;
            busy_q       <= 1'b1;
            frame_done_q <= 1'b0;
            row_q        <= '0;
          end
        end
        FETCH: begin
          row_data_q  <= rd_data;
          row_idx_q   <= row_q;
          row_valid_q <= 1'b1;
          state_q     <= PRESENT;
        end
        PRESENT: begin
          if (row_ready) begin
            row_valid_q <= 1'b0;
            if (row_q == LAST_ROW) begin
              busy_q       <= 1'b0;
              frame_done_q <= 1'b1;
              state_q      <= IDLE;
            end else begin
              row_q   <= row_q + RW'(1);
              state_q <= FETCH;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign row_valid  = row_valid_q;
  assign row_data   = row_data_q;
  assign row_idx    = row_idx_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: rtl/data_mem_responder.sv
// CPU data-memory port: word RAM with combinational loads, an MMIO page
// (CYCLE / CTRL / FB_BASE) and a framebuffer scan-out engine.
// Optional free-running CYCLE counter is built when DMEM_CYCLE_CNT_EN is defined.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter int          FB_ROWS   = 32,
  parameter logic [31:0] MMIO_BASE = 32'h1000_0000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [31:0]                addr,
  input  logic                       mem_write,
  input  logic [31:0]                write_data,
  output logic [31:0]                read_data,
  output logic                       row_valid,
  input  logic                       row_ready,
  output logic [31:0]                row_data,
  output logic [$clog2(FB_ROWS)-1:0] row_idx,
  output logic                       frame_done
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   ram [DEPTH];
  logic [AW-1:0] cpu_word;
  logic [AW-1:0] scan_addr;
  logic [31:0]   scan_rdata;
  logic [AW-1:0] fb_base_q;
  logic [AW-1:0] fb_base_d;
  logic [31:0]   cycle_val;
  logic [31:0]   mmio_rdata;
  logic [11:0]   mmio_off;
  logic          is_ram;
  logic          is_mmio;
  logic          busy;
  logic          ctrl_start;
  logic          unused_addr_lsb;

  assign cpu_word        = addr[AW+1:2];
  assign is_ram          = (addr[31:AW+2] == '0);
  assign is_mmio         = (addr[31:12] == MMIO_BASE[31:12]);
  assign mmio_off        = {addr[11:2], 2'b00};
  assign unused_addr_lsb = ^addr[1:0];

  // No reset on the array; the scan port reads old data on a same-edge store.
  always_ff @(posedge clk) begin
    if (mem_write && is_ram) begin
      ram[cpu_word] <= write_data;
    end
  end

  assign scan_rdata = ram[scan_addr];

  always_comb begin
    fb_base_d = fb_base_q;
    if (mem_write && is_mmio && (mmio_off == OFF_FB_BASE)) begin
      fb_base_d = write_data[AW-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fb_base_q <= '0;
    end else begin
      fb_base_q <= fb_base_d;
    end
  end

  assign ctrl_start = mem_write && is_mmio && (mmio_off == OFF_CTRL) &&
                      write_data[CTRL_START_BIT];

`ifdef DMEM_CYCLE_CNT_EN
  logic [31:0] cycle_q;
  logic [31:0] cycle_d;

  always_comb begin
    cycle_d = cycle_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_q <= '0;
    end else begin
      cycle_q <= cycle_d;
    end
  end

  assign cycle_val = cycle_q;
`else
  assign cycle_val = '0;
`endif

  always_comb begin
    mmio_rdata = '0;
    case (mmio_off)
      OFF_CYCLE: mmio_rdata = cycle_val;
      OFF_CTRL: begin
        mmio_rdata[CTRL_BUSY_BIT] = busy;
        mmio_rdata[CTRL_DONE_BIT] = frame_done;
      end
      OFF_FB_BASE: mmio_rdata = 32'(fb_base_q);
      default: mmio_rdata = '0;
    endcase
  end

  always_comb begin
    read_data = '0;
    if (is_ram) begin
      read_data = ram[cpu_word];
    end else if (is_mmio) begin
      read_data = mmio_rdata;
    end
  end

  dmem_scanout #(
    .AW      (AW),
    .FB_ROWS (FB_ROWS)
  ) u_scanout (
    .clk        (clk),
    .reset      (reset),
    .start      (ctrl_start),
    .fb_base    (fb_base_q),
    .rd_addr    (scan_addr),
    .rd_data    (scan_rdata),
    .row_ready  (row_ready),
    .row_valid  (row_valid),
    .row_data   (row_data),
    .row_idx    (row_idx),
    .busy       (busy),
    .frame_done (frame_done)
  );

endmodule
